// File: rtl/alu_op_sequencer.sv
// Issues add/sub/and/asr/cmp/mul requests to an external combinational ALU and returns registered responses.
// Single ops respond one cycle after accept, MUL after MUL_BITS cycles; holds response until rsp_ready.
module alu_op_sequencer #(
  parameter int MUL_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_funct,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        flag_z,
  output logic        flag_c
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [5:0] CNT_LAST = 6'(MUL_BITS - 1);

  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_a;       // operand A, or accumulator during MUL
  logic [31:0] r_b;       // operand B, or shifted multiplicand during MUL
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_zero, r_carry, r_err, r_flag_z, r_flag_c;

  logic        w_accept, w_illegal, w_mul_done, w_uses_c;
  logic [31:0] w_acc_next;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_illegal  = req_op[2] & req_op[1];
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_uses_c   = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_CMP);
  assign w_acc_next = r_mplier[0] ? alu_out : r_a;

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_carry  = r_carry;
  assign rsp_err    = r_err;
  assign flag_z     = r_flag_z;
  assign flag_c     = r_flag_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_funct = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_illegal)             w_next = S_RESP;
          else if (req_op == OP_MUL) w_next = S_MUL;
          else                       w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a  = r_a;
        alu_b  = r_b;
        w_next = S_RESP;
        case (r_op)
          OP_SUB, OP_CMP: alu_funct = 2'b01;
          OP_AND:         alu_funct = 2'b10;
          OP_ASR:         alu_funct = 2'b11;
          default:        alu_funct = 2'b00;
        endcase
      end
      S_MUL: begin
        alu_a = r_a;
        alu_b = r_b;
        if (w_mul_done) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 6'd0;
      r_result <= 32'd0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= req_op;
        if (req_op == OP_MUL) begin
          r_a      <= 32'd0;
          r_b      <= req_a;
          r_mplier <= req_b;
          r_cnt    <= 6'd0;
        end else begin
          r_a <= req_a;
          r_b <= req_b;
        end
        if (w_illegal) begin
          r_result <= 32'd0;
          r_zero   <= 1'b0;
          r_carry  <= 1'b0;
          r_err    <= 1'b1;
        end
      end
      if (r_state == S_EXEC) begin
        r_result <= (r_op == OP_CMP) ? 32'd0 : alu_out;
        r_zero   <= alu_zero;
        r_carry  <= w_uses_c ? alu_carry : 1'b0;
        r_err    <= 1'b0;
        r_flag_z <= alu_zero;
        if (w_uses_c) r_flag_c <= alu_carry;
      end
      if (r_state == S_MUL) begin
        r_a      <= w_acc_next;
        r_b      <= r_b << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 6'd1;
        if (w_mul_done) begin
          r_result <= w_acc_next;
          r_zero   <= (w_acc_next == 32'd0);
          r_carry  <= 1'b0;
          r_err    <= 1'b0;
          r_flag_z <= (w_acc_next == 32'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (MUL_BITS 32 and 8) on a behavioural ALU,
// directed test-plan cases then random ops against an arithmetic reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_valid_v [2];
  logic        req_ready_v [2];
  logic [31:0] alu_a_v [2];
  logic [31:0] alu_b_v [2];
  logic [1:0]  alu_funct_v [2];
  logic [31:0] alu_out_v [2];
  logic        alu_zero_v [2];
  logic        alu_carry_v [2];
  logic        rsp_valid_v [2];
  logic        rsp_ready_v [2];
  logic [31:0] rsp_result_v [2];
  logic        rsp_zero_v [2];
  logic        rsp_carry_v [2];
  logic        rsp_err_v [2];
  logic        flag_z_v [2];
  logic        flag_c_v [2];

  int n_pass = 0;
  int n_fail = 0;
  logic mfz [2];
  logic mfc [2];

  always #5 clk = ~clk;

  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    logic [32:0] s;
    logic [31:0] o;
    logic        c;
    s = 33'd0;
    case (f)
      2'b00:   begin s = {1'b0, a} + {1'b0, b};          o = s[31:0]; c = s[32]; end
      2'b01:   begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; o = s[31:0]; c = s[32]; end
      2'b10:   begin o = a & b; c = 1'b0; end
      default: begin o = $unsigned($signed(a) >>> b[4:0]); c = 1'b0; end
    endcase
    return {c, (o == 32'd0), o};
  endfunction

  assign {alu_carry_v[0], alu_zero_v[0], alu_out_v[0]} = alu_f(alu_a_v[0], alu_b_v[0], alu_funct_v[0]);
  assign {alu_carry_v[1], alu_zero_v[1], alu_out_v[1]} = alu_f(alu_a_v[1], alu_b_v[1], alu_funct_v[1]);

  alu_op_sequencer #(.MUL_BITS(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a_v[0]), .alu_b(alu_b_v[0]), .alu_funct(alu_funct_v[0]),
    .alu_out(alu_out_v[0]), .alu_zero(alu_zero_v[0]), .alu_carry(alu_carry_v[0]),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]), .rsp_result(rsp_result_v[0]),
    .rsp_zero(rsp_zero_v[0]), .rsp_carry(rsp_carry_v[0]), .rsp_err(rsp_err_v[0]),
    .flag_z(flag_z_v[0]), .flag_c(flag_c_v[0])
  );

  alu_op_sequencer #(.MUL_BITS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a_v[1]), .alu_b(alu_b_v[1]), .alu_funct(alu_funct_v[1]),
    .alu_out(alu_out_v[1]), .alu_zero(alu_zero_v[1]), .alu_carry(alu_carry_v[1]),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]), .rsp_result(rsp_result_v[1]),
    .rsp_zero(rsp_zero_v[1]), .rsp_carry(rsp_carry_v[1]), .rsp_err(rsp_err_v[1]),
    .flag_z(flag_z_v[1]), .flag_c(flag_c_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected response straight from the operation definitions; also advances the flag model.
  task automatic model(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output logic c, output logic err, output int lat);
    int          mb;
    logic [31:0] m;
    logic [32:0] wide;
    mb  = (d == 0) ? 32 : 8;
    err = 1'b0; c = 1'b0; z = 1'b0; res = 32'd0; lat = 1;
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[31:0]; c = wide[32]; z = (res == 0); end
      3'd1: begin res = a - b; c = (a >= b); z = (res == 0); end
      3'd2: begin res = a & b; z = (res == 0); end
      3'd3: begin res = $unsigned($signed(a) >>> b[4:0]); z = (res == 0); end
      3'd4: begin res = 32'd0; c = (a >= b); z = (a == b); end
      3'd5: begin
        m   = (mb >= 32) ? b : (b & ((32'd1 << mb) - 32'd1));
        res = a * m; z = (res == 0); lat = mb;
      end
      default: begin err = 1'b1; lat = 0; end
    endcase
    if (!err) begin
      mfz[d] = z;
      if (op == 3'd0 || op == 3'd1 || op == 3'd4) mfc[d] = c;
    end
  endtask

  // Called at a negedge; returns at a negedge with the response consumed.
  task automatic run(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input bit nxt, input logic [2:0] nop, input logic [31:0] na,
                     input logic [31:0] nb);
    logic [31:0] eres;
    logic        ez, ec, eerr;
    int          elat, lat, w, badf;
    model(d, op, a, b, eres, ez, ec, eerr, elat);
    w = 0;
    while (!req_ready_v[d] && w < 100) begin @(negedge clk); w++; end
    chk("req_ready_before_issue", 32'(req_ready_v[d]), 32'd1);
    req_op = op; req_a = a; req_b = b; req_valid_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_v[d] = 1'b0;
    lat = 0; badf = 0;
    while (!rsp_valid_v[d] && lat < 100) begin
      if (op == 3'd5 && alu_funct_v[d] != 2'b00) badf++;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    if (op == 3'd5) chk("mul_funct_bad_cycles", 32'(badf), 32'd0);
    chk("rsp_result", rsp_result_v[d], eres);
    chk("rsp_zero", 32'(rsp_zero_v[d]), 32'(ez));
    chk("rsp_carry", 32'(rsp_carry_v[d]), 32'(ec));
    chk("rsp_err", 32'(rsp_err_v[d]), 32'(eerr));
    chk("flag_z", 32'(flag_z_v[d]), 32'(mfz[d]));
    chk("flag_c", 32'(flag_c_v[d]), 32'(mfc[d]));
    if (nxt) begin
      req_op = nop; req_a = na; req_b = nb; req_valid_v[d] = 1'b1;
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("hold_rsp_valid", 32'(rsp_valid_v[d]), 32'd1);
      chk("hold_rsp_result", rsp_result_v[d], eres);
      chk("hold_req_ready", 32'(req_ready_v[d]), 32'd0);
    end
    rsp_ready_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_v[d] = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid_v[d]), 32'd0);
    chk("flag_z_after_hs", 32'(flag_z_v[d]), 32'(mfz[d]));
    chk("flag_c_after_hs", 32'(flag_c_v[d]), 32'(mfc[d]));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          rd;
    rst_n = 1'b0;
    req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    for (int i = 0; i < 2; i++) begin
      req_valid_v[i] = 1'b0; rsp_ready_v[i] = 1'b0; mfz[i] = 1'b0; mfc[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready_v[0]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    chk("reset_rsp_result", rsp_result_v[0], 32'd0);
    chk("reset_flags", {30'd0, flag_z_v[0], flag_c_v[0]}, 32'd0);
    chk("reset_alu_funct", 32'(alu_funct_v[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 3'd0, 0, 0);
    run(0, 3'd1, 32'd5, 32'd7, 0, 0, 3'd0, 0, 0);
    run(0, 3'd4, 32'd7, 32'd7, 0, 0, 3'd0, 0, 0);
    run(0, 3'd5, 32'h0001_0003, 32'd5, 0, 0, 3'd0, 0, 0);
    run(1, 3'd5, 32'h1234_5678, 32'h100, 0, 0, 3'd0, 0, 0);
    run(1, 3'd5, 32'h0000_0101, 32'hFFFF_FF0B, 0, 0, 3'd0, 0, 0);
    // AND held off for 5 cycles while an ASR is already waiting behind it
    run(0, 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5, 1, 3'd3, 32'h8000_0000, 32'd4);
    run(0, 3'd3, 32'h8000_0000, 32'd4, 0, 0, 3'd0, 0, 0);
    run(0, 3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 3'd0, 0, 0);
    run(0, 3'd6, 32'h1111_1111, 32'h2222_2222, 2, 0, 3'd0, 0, 0);
    run(0, 3'd7, 32'd0, 32'd0, 0, 0, 3'd0, 0, 0);

    // Reset during MUL cycle 10 aborts the operation
    req_op = 3'd5; req_a = 32'd77; req_b = 32'hFFFF_FFFF; req_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin mfz[i] = 1'b0; mfc[i] = 1'b0; end
    chk("rst_mid_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    chk("rst_mid_flags", {30'd0, flag_z_v[0], flag_c_v[0]}, 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready_v[0]), 32'd1);
    chk("rst_mid_alu_funct", 32'(alu_funct_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
    run(0, 3'd0, 32'd2, 32'd3, 0, 0, 3'd0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      rd  = ($urandom_range(0, 4) == 0) ? 1 : 0;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(0, 40));
        default: ;
      endcase
      run(rd, rop, ra, rb, $urandom_range(0, 3), 0, 3'd0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Initiator-side controller for the combinational ALU (add/sub/and/asr, 2-bit function select, zero and carry flags). It accepts operation requests over a valid/ready handshake and drives the ALU operand and function inputs. It registers the ALU result and flags into a response with valid/ready handshake, maintains persistent Z/C flag registers, and runs a multi-cycle shift-add multiply that reuses the ALU adder. It sits between the decode/issue logic and the ALU.

## Interface
- MUL_BITS, default 32: number of low multiplier bits consumed by MUL (1..32); sets MUL latency.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  3  000 ADD, 001 SUB, 010 AND, 011 ASR, 100 CMP, 101 MUL, 110/111 illegal
- req_a, req_b  in  32  operands
- alu_a, alu_b  out  32  ALU operands
- alu_funct  out  2  00 add, 01 sub, 10 and, 11 asr
- alu_out  in  32  ALU result
- alu_zero, alu_carry  in  1  ALU flags; carry is adder carry-out (SUB: 1 = no borrow)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  registered result
- rsp_zero, rsp_carry, rsp_err  out  1  registered flags, illegal-op indicator
- flag_z, flag_c  out  1  persistent flag registers

## Operation
- States: IDLE, EXEC, MUL, RESP. Reset -> IDLE. All registers, including rsp_* and flag_*, are 0 in reset. req_ready is decoded from state, so it is 1 in reset.
- IDLE: on req_valid, capture op/a/b at the edge. Next state is EXEC for ADD/SUB/AND/ASR/CMP. For MUL, next state is MUL with acc=0, mcand=req_a, mplier=req_b, cnt=0. For illegal ops, next state is RESP with result=0, err=1, zero=0, carry=0.
- EXEC, one cycle: drive alu_a=a, alu_b=b, alu_funct per op (CMP uses 01). At the edge, register:
  - result: alu_out, forced to 0 for CMP.
  - zero: alu_zero.
  - carry: alu_carry for ADD/SUB/CMP, 0 for AND/ASR.
  - Next state RESP.
- MUL: each cycle drive alu_a=acc, alu_b=mcand, alu_funct=00. At the edge:
  - acc<=alu_out if mplier[0]=1;
  - mcand<<=1 (logical);
  - mplier>>=1;
  - cnt++.
  - When cnt reaches MUL_BITS-1, go to RESP with result=final acc, zero=(result==0), carry=0.
  - Result is product modulo 2^32. There is no early exit.
- RESP: rsp_valid=1. rsp_* hold stable until rsp_ready=1; at that edge go to IDLE. A new request is not accepted in the same edge.
- Outside EXEC/MUL: alu_a=alu_b=0, alu_funct=00.
- Flag register update, at the same edge the response is registered:
  - ADD, SUB, CMP: Z and C.
  - AND, ASR, MUL: Z only, C unchanged.
  - Illegal: no update.
- Reset asserted mid-operation aborts immediately: no response issued, flags cleared, captured operands discarded.

## Timing
- Request accepted at edge T0 (req_valid & req_ready).
- Single-cycle ops: rsp_valid high after edge T0+1; earliest next accept at T0+3 with rsp_ready held high.
- MUL: rsp_valid high after edge T0+MUL_BITS; 32 cycles at default.
- Illegal op: rsp_valid high after edge T0.
- Response handshake: at the edge with rsp_valid & rsp_ready. rsp_valid drops the following cycle.
- Flags change exactly at the response-register edge, never at the handshake edge.
- req_ready is 0 from T0+1 until the cycle after the response handshake. Requests during this window are ignored; the requester holds them.
- No combinational path from req_* or rsp_ready to alu_* or rsp_*.

## Test plan
- ADD a=0xFFFFFFFF, b=1, rsp_ready=1 -> rsp_result=0, rsp_zero=1, rsp_carry=1, rsp_valid after T0+1, flag_z=1, flag_c=1.
- SUB 5-7 -> result 0xFFFFFFFE, zero=0, carry=0. Then CMP 7,7 -> result 0, zero=1, carry=1, flag_c=1.
- MUL a=0x00010003, b=5 -> result 0x0005000F, rsp_valid after T0+32, alu_funct=00 every MUL cycle. Also run MUL_BITS=8 with b=0x100 -> result 0.
- Backpressure: AND 0xF0F0F0F0, 0x0FF00FF0 with rsp_ready low 5 cycles -> rsp_result=0x00F000F0 stable, req_ready=0, second queued ASR 0x80000000>>4 -> 0xF8000000 returned only after first handshake.
- Illegal op 3'b110 after ADD set flag_c=1 -> rsp_err=1, rsp_result=0, flag_z/flag_c unchanged.
- Assert rst_n low during MUL cycle 10 -> rsp_valid=0, flag_z=flag_c=0, req_ready=1, alu_funct=00. After release, ADD 2+3 -> 5.
